// File: rtl/spi_slave_axis_rfg_protocol.sv
// spi_slave_axis_rfg_protocol
//
// Decodes the byte stream that arrives from the SPI slave ingress stage. A
// frame is CMD, ADDR, LEN and then data. The decoder drives register-file
// write and read strobes. Read data goes back as an AXIS byte stream toward
// the SPI egress path.
//
// Ports
//   clk, res            clock; asynchronous active-high reset. The source
//                       must release reset synchronously to clk.
//   s_axis_*            incoming bytes. tready is always 1. tdest and tid
//                       are sampled together with the CMD byte.
//   m_axis_*            read-response bytes. tdest and tid are the values
//                       captured with CMD.
//   rfg_address         current register address (ADDR byte, zero-extended)
//   rfg_write           1-cycle write strobe, qualified by rfg_write_value
//   rfg_read            1-cycle read strobe; rfg_read_value is expected on
//                       the following cycle
//   frame_error         1-cycle pulse when a frame is aborted by the timeout
//
// CMD byte: bit 7 = write (0 = read), bit 6 = auto-increment the address,
// bits 5:0 are ignored. LEN = 0 means 256 bytes.
module spi_slave_axis_rfg_protocol #(
  parameter int AW             = 8,
  parameter int DEST_WIDTH     = 8,
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [AW-1:0]         rfg_address,
  output logic                  rfg_write,
  output logic [7:0]            rfg_write_value,
  output logic                  rfg_read,
  input  logic [7:0]            rfg_read_value,
  output logic                  frame_error
);

  // The idle counter never needs to hold more than TIMEOUT_CYCLES-1.
  localparam int TCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_WDATA,
    S_RREQ,
    S_RWAIT,
    S_RSEND
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_is_write;
  logic                  r_inc;
  logic [AW-1:0]         r_addr;
  logic [8:0]            r_count;
  logic [TCW-1:0]        r_idle;
  logic [DEST_WIDTH-1:0] r_tdest;
  logic [ID_WIDTH-1:0]   r_tid;
  logic                  r_rfg_write;
  logic [7:0]            r_write_value;
  logic [7:0]            r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_frame_error;

  logic w_in_frame;
  logic w_timeout;
  logic w_byte;
  logic w_handshake;
  logic w_rfg_read;

  // The timeout only runs while a frame header or its write data is still
  // expected. The timeout cycle is the TIMEOUT_CYCLES-th cycle after the last
  // accepted byte. A byte that arrives in that cycle loses to the abort.
  assign w_in_frame  = (r_state == S_ADDR) || (r_state == S_LEN) || (r_state == S_WDATA);
  assign w_timeout   = w_in_frame && (r_idle == TCW'(TIMEOUT_CYCLES - 1));
  assign w_byte      = s_axis_tvalid && !w_timeout;
  assign w_handshake = (r_state == S_RSEND) && r_m_tvalid && m_axis_tready;

  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Bytes seen in the read states are SPI dummy bytes. No transition
  // consumes them there.
  always_comb begin
    w_next_state = r_state;
    w_rfg_read   = 1'b0;
    if (w_timeout) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (s_axis_tvalid) w_next_state = S_ADDR;
        S_ADDR:  if (w_byte) w_next_state = S_LEN;
        S_LEN:   if (w_byte) w_next_state = r_is_write ? S_WDATA : S_RREQ;
        S_WDATA: if (w_byte && (r_count == 9'd1)) w_next_state = S_IDLE;
        S_RREQ: begin
          w_rfg_read   = 1'b1;
          w_next_state = S_RWAIT;
        end
        S_RWAIT: w_next_state = S_RSEND;
        S_RSEND: if (w_handshake) w_next_state = (r_count == 9'd1) ? S_IDLE : S_RREQ;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // The write strobe is issued one cycle after its data byte. The address
  // advances after the strobe cycle. On the final byte, the FSM is already
  // back in IDLE while the strobe is out, so the next byte is taken as a new
  // CMD.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_is_write    <= 1'b0;
      r_inc         <= 1'b0;
      r_addr        <= '0;
      r_count       <= '0;
      r_idle        <= '0;
      r_tdest       <= '0;
      r_tid         <= '0;
      r_rfg_write   <= 1'b0;
      r_write_value <= '0;
      r_m_tdata     <= '0;
      r_m_tvalid    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_frame_error <= w_timeout;
      r_rfg_write   <= (r_state == S_WDATA) && w_byte;

      if (!w_in_frame || s_axis_tvalid || w_timeout) r_idle <= '0;
      else                                           r_idle <= r_idle + TCW'(1);

      if (r_rfg_write && r_inc) r_addr <= r_addr + AW'(1);

      case (r_state)
        S_IDLE: begin
          if (s_axis_tvalid) begin
            r_is_write <= s_axis_tdata[7];
            r_inc      <= s_axis_tdata[6];
            r_tdest    <= s_axis_tdest;
            r_tid      <= s_axis_tid;
          end
        end
        S_ADDR: if (w_byte) r_addr <= AW'(s_axis_tdata);
        S_LEN: begin
          if (w_byte) r_count <= (s_axis_tdata == 8'd0) ? 9'd256 : {1'b0, s_axis_tdata};
        end
        S_WDATA: begin
          if (w_byte) begin
            r_write_value <= s_axis_tdata;
            r_count       <= r_count - 9'd1;
          end
        end
        S_RWAIT: begin
          r_m_tdata  <= rfg_read_value;
          r_m_tvalid <= 1'b1;
        end
        S_RSEND: begin
          if (w_handshake) begin
            r_m_tvalid <= 1'b0;
            r_count    <= r_count - 9'd1;
            if (r_inc) r_addr <= r_addr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axis_tready   = 1'b1;
  assign m_axis_tdata    = r_m_tdata;
  assign m_axis_tvalid   = r_m_tvalid;
  assign m_axis_tdest    = r_tdest;
  assign m_axis_tid      = r_tid;
  assign rfg_address     = r_addr;
  assign rfg_write       = r_rfg_write;
  assign rfg_write_value = r_write_value;
  assign rfg_read        = w_rfg_read;
  assign frame_error     = r_frame_error;

endmodule

// File: tb/tb_spi_slave_axis_rfg_protocol.sv
// tb_spi_slave_axis_rfg_protocol
//
// Drives CMD/ADDR/LEN/data frames into the decoder. A register-file ROM
// answers read strobes. Expected strobes, response bytes and error pulses
// come from a frame-level model, and are compared with what a passive
// monitor records.
module tb_spi_slave_axis_rfg_protocol;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdest = 8'h00;
  logic [7:0] s_axis_tid = 8'h00;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic [7:0] m_axis_tdest;
  logic [7:0] m_axis_tid;
  logic [7:0] rfg_address;
  logic       rfg_write;
  logic [7:0] rfg_write_value;
  logic       rfg_read;
  logic [7:0] rfg_read_value = 8'h00;
  logic       frame_error;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ready_mode = 0;
  int last_cyc = 0;

  logic [7:0] rom [256];

  int got_wa[$], got_wd[$], got_wc[$], got_ra[$], got_rc[$];
  int got_md[$], got_mdest[$], got_mid[$], got_mc[$], got_fe[$];
  int exp_wa[$], exp_wd[$], exp_wc[$], exp_ra[$];
  int exp_md[$], exp_mdest[$], exp_mid[$];

  spi_slave_axis_rfg_protocol #(
    .AW(8), .DEST_WIDTH(8), .ID_WIDTH(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .res(res),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdest(s_axis_tdest), .s_axis_tid(s_axis_tid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdest(m_axis_tdest), .m_axis_tid(m_axis_tid),
    .rfg_address(rfg_address), .rfg_write(rfg_write), .rfg_write_value(rfg_write_value),
    .rfg_read(rfg_read), .rfg_read_value(rfg_read_value), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Cycle k is the interval after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // The register file answers a read strobe on the following cycle.
  always @(posedge clk) if (rfg_read) rfg_read_value <= rom[rfg_address];

  // Response ready: 0 = low, 1 = high, other = random every cycle.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Passive recorder, sampling mid-cycle.
  always @(negedge clk) begin
    if (!res) begin
      if (rfg_write) begin
        got_wa.push_back(int'(rfg_address));
        got_wd.push_back(int'(rfg_write_value));
        got_wc.push_back(cyc);
      end
      if (rfg_read) begin
        got_ra.push_back(int'(rfg_address));
        got_rc.push_back(cyc);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_md.push_back(int'(m_axis_tdata));
        got_mdest.push_back(int'(m_axis_tdest));
        got_mid.push_back(int'(m_axis_tid));
        got_mc.push_back(cyc);
      end
      if (frame_error) got_fe.push_back(cyc);
    end
  end

  task automatic clear_all();
    got_wa.delete(); got_wd.delete(); got_wc.delete(); got_ra.delete(); got_rc.delete();
    got_md.delete(); got_mdest.delete(); got_mid.delete(); got_mc.delete(); got_fe.delete();
    exp_wa.delete(); exp_wd.delete(); exp_wc.delete(); exp_ra.delete();
    exp_md.delete(); exp_mdest.delete(); exp_mid.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    last_cyc      = cyc;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'($urandom);
    s_axis_tdest  = 8'($urandom);
    s_axis_tid    = 8'($urandom);
  endtask

  // Write frame plus model: data byte i goes to start + i (auto-increment,
  // mod 256) or to start. Its strobe is seen on the cycle after the byte.
  task automatic send_write_frame(input logic [7:0] cmd, input logic [7:0] addr,
                                  input logic [7:0] len, input int gap);
    int n;
    logic [7:0] d;
    logic [7:0] a;
    n = (len == 8'd0) ? 256 : int'(len);
    send_byte(cmd);
    send_byte(addr);
    send_byte(len);
    for (int i = 0; i < n; i++) begin
      idle(gap);
      d = 8'($urandom);
      send_byte(d);
      a = addr + (cmd[6] ? 8'(i) : 8'd0);
      exp_wa.push_back(int'(a));
      exp_wd.push_back(int'(d));
      exp_wc.push_back(last_cyc + 1);
    end
  endtask

  // Read frame header plus model: n reads of consecutive (or identical)
  // addresses, and each response carries the ROM byte and the CMD-time tags.
  task automatic send_read_frame(input logic [7:0] cmd, input logic [7:0] addr,
                                 input logic [7:0] len, output int len_cyc);
    int n;
    logic [7:0] a;
    logic [7:0] dest;
    logic [7:0] id;
    n = (len == 8'd0) ? 256 : int'(len);
    dest = 8'($urandom);
    id   = 8'($urandom);
    s_axis_tdest = dest;
    s_axis_tid   = id;
    send_byte(cmd);
    send_byte(addr);
    send_byte(len);
    len_cyc = last_cyc;
    for (int i = 0; i < n; i++) begin
      a = addr + (cmd[6] ? 8'(i) : 8'd0);
      exp_ra.push_back(int'(a));
      exp_md.push_back(int'(rom[a]));
      exp_mdest.push_back(int'(dest));
      exp_mid.push_back(int'(id));
    end
  endtask

  task automatic wait_reads(input int limit);
    int n;
    n = 0;
    while (got_md.size() < exp_md.size() && n < limit) begin
      idle(1);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] got [10];
    logic [31:0] expv [10];
    string nm [10];
    nm   = '{"tready", "m_tvalid", "m_tdata", "m_tdest", "m_tid", "rfg_write",
             "rfg_wvalue", "rfg_read", "rfg_address", "frame_error"};
    expv = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        res = 1'b1;
        repeat (3) @(posedge clk);
        #1;
      end else begin
        res = 1'b0;
        idle(3);
      end
      got[0] = 32'(s_axis_tready);   got[1] = 32'(m_axis_tvalid);
      got[2] = 32'(m_axis_tdata);    got[3] = 32'(m_axis_tdest);
      got[4] = 32'(m_axis_tid);      got[5] = 32'(rfg_write);
      got[6] = 32'(rfg_write_value); got[7] = 32'(rfg_read);
      got[8] = 32'(rfg_address);     got[9] = 32'(frame_error);
      for (int i = 0; i < 10; i++) begin
        vectors++;
        if (got[i] !== expv[i]) begin
          miscompares++;
          $display("[TB] FAIL reset_%s (pass %0d): got %0h expected %0h", nm[i], pass, got[i], expv[i]);
        end
      end
    end
  endtask

  task automatic test_write_basic();
    clear_all();
    send_write_frame(8'hC0, 8'h10, 8'h02, 0);
    idle(4);
    vectors++;
    if (got_wa.size() != 2 || exp_wa.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL write_basic_count: got %0d expected 2", got_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
      vectors++;
      if (got_wa[i] !== 16 + i || got_wd[i] !== exp_wd[i] || got_wc[i] !== exp_wc[i]) begin
        miscompares++;
        $display("[TB] FAIL write_basic[%0d]: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                 i, got_wa[i], got_wd[i], got_wc[i], 16 + i, exp_wd[i], exp_wc[i]);
      end
    end
  endtask

  task automatic test_write_random();
    clear_all();
    for (int f = 0; f < 6; f++) begin
      send_write_frame({1'b1, 1'($urandom), 6'($urandom)}, 8'($urandom),
                       8'($urandom_range(1, 6)), $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end
    idle(4);
    vectors++;
    if (got_wa.size() != exp_wa.size()) begin
      miscompares++;
      $display("[TB] FAIL write_random_count: got %0d expected %0d", got_wa.size(), exp_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
      vectors++;
      if (got_wa[i] !== exp_wa[i] || got_wd[i] !== exp_wd[i] || got_wc[i] !== exp_wc[i]) begin
        miscompares++;
        $display("[TB] FAIL write_random[%0d]: got addr %0h data %0h cyc %0d expected addr %0h data %0h cyc %0d",
                 i, got_wa[i], got_wd[i], got_wc[i], exp_wa[i], exp_wd[i], exp_wc[i]);
      end
    end
    vectors++;
    if (got_ra.size() != 0 || got_fe.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL write_random_side: got reads %0d errors %0d expected 0 0", got_ra.size(), got_fe.size());
    end
  endtask

  task automatic test_read_basic();
    int k;
    ready_mode = 1;
    idle(2);
    clear_all();
    send_read_frame(8'h40, 8'hFF, 8'h02, k);
    wait_reads(40);
    idle(3);
    vectors++;
    if (got_ra.size() != 2 || got_md.size() != 2) begin
      miscompares++;
      $display("[TB] FAIL read_basic_count: got reads %0d bytes %0d expected 2 2", got_ra.size(), got_md.size());
    end
    for (int i = 0; i < 2 && i < got_ra.size() && i < got_md.size(); i++) begin
      vectors++;
      if (got_ra[i] !== exp_ra[i] || got_rc[i] !== k + 1 + 3 * i) begin
        miscompares++;
        $display("[TB] FAIL read_basic_strobe[%0d]: got addr %0h cyc %0d expected addr %0h cyc %0d",
                 i, got_ra[i], got_rc[i], exp_ra[i], k + 1 + 3 * i);
      end
      vectors++;
      if (got_md[i] !== exp_md[i] || got_mdest[i] !== exp_mdest[i] || got_mid[i] !== exp_mid[i]
          || got_mc[i] !== k + 3 + 3 * i) begin
        miscompares++;
        $display("[TB] FAIL read_basic_byte[%0d]: got %0h/%0h/%0h cyc %0d expected %0h/%0h/%0h cyc %0d",
                 i, got_md[i], got_mdest[i], got_mid[i], got_mc[i],
                 exp_md[i], exp_mdest[i], exp_mid[i], k + 3 + 3 * i);
      end
    end
  endtask

  task automatic test_read_random();
    int k;
    ready_mode = 2;
    idle(2);
    clear_all();
    for (int f = 0; f < 5; f++) begin
      send_read_frame({1'b0, 1'($urandom), 6'($urandom)}, 8'($urandom), 8'($urandom_range(1, 5)), k);
      wait_reads(200);
      idle($urandom_range(0, 2));
    end
    idle(3);
    vectors++;
    if (got_ra.size() != exp_ra.size() || got_md.size() != exp_md.size()) begin
      miscompares++;
      $display("[TB] FAIL read_random_count: got reads %0d bytes %0d expected %0d %0d",
               got_ra.size(), got_md.size(), exp_ra.size(), exp_md.size());
    end
    for (int i = 0; i < exp_ra.size() && i < got_ra.size(); i++) begin
      vectors++;
      if (got_ra[i] !== exp_ra[i]) begin
        miscompares++;
        $display("[TB] FAIL read_random_addr[%0d]: got %0h expected %0h", i, got_ra[i], exp_ra[i]);
      end
    end
    for (int i = 0; i < exp_md.size() && i < got_md.size(); i++) begin
      vectors++;
      if (got_md[i] !== exp_md[i] || got_mdest[i] !== exp_mdest[i] || got_mid[i] !== exp_mid[i]) begin
        miscompares++;
        $display("[TB] FAIL read_random_byte[%0d]: got %0h/%0h/%0h expected %0h/%0h/%0h",
                 i, got_md[i], got_mdest[i], got_mid[i], exp_md[i], exp_mdest[i], exp_mid[i]);
      end
    end
  endtask

  task automatic test_read_stall();
    int k;
    int n;
    ready_mode = 0;
    idle(2);
    clear_all();
    send_read_frame({2'b00, 6'($urandom)}, 8'($urandom), 8'h02, k);
    n = 0;
    while (m_axis_tvalid !== 1'b1 && n < 20) begin
      idle(1);
      n++;
    end
    vectors++;
    if (m_axis_tvalid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_first_valid: got tvalid %b expected 1 within 20 cycles", m_axis_tvalid);
    end
    // Stall well past the frame timeout while dummy bytes stream in.
    for (int i = 0; i < TO + 5; i++) begin
      send_byte(8'($urandom));
      vectors++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_md[0][7:0] || m_axis_tdest !== exp_mdest[0][7:0]) begin
        miscompares++;
        $display("[TB] FAIL stall_hold[%0d]: got tvalid %b tdata %0h tdest %0h expected 1 %0h %0h",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tdest, exp_md[0], exp_mdest[0]);
      end
    end
    ready_mode = 1;
    wait_reads(40);
    idle(3);
    vectors++;
    if (got_ra.size() != 2 || got_md.size() != 2 || got_fe.size() != 0 || got_wa.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stall_totals: got reads %0d bytes %0d errors %0d writes %0d expected 2 2 0 0",
               got_ra.size(), got_md.size(), got_fe.size(), got_wa.size());
    end
    for (int i = 0; i < got_md.size() && i < 2; i++) begin
      vectors++;
      if (got_md[i] !== exp_md[i] || got_ra[i] !== exp_ra[i]) begin
        miscompares++;
        $display("[TB] FAIL stall_byte[%0d]: got addr %0h data %0h expected addr %0h data %0h",
                 i, got_ra[i], got_md[i], exp_ra[i], exp_md[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int k;
    // Longest tolerated gap: TO-2 silent cycles between bytes.
    clear_all();
    send_write_frame(8'hC0, 8'($urandom), 8'h02, TO - 2);
    idle(4);
    vectors++;
    if (got_wa.size() != 2 || got_fe.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL timeout_near_miss: got writes %0d errors %0d expected 2 0", got_wa.size(), got_fe.size());
    end
    for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
      vectors++;
      if (got_wa[i] !== exp_wa[i] || got_wd[i] !== exp_wd[i] || got_wc[i] !== exp_wc[i]) begin
        miscompares++;
        $display("[TB] FAIL timeout_near_miss_write[%0d]: got %0h=%0h@%0d expected %0h=%0h@%0d",
                 i, got_wa[i], got_wd[i], got_wc[i], exp_wa[i], exp_wd[i], exp_wc[i]);
      end
    end
    // CMD, ADDR, then silence.
    clear_all();
    send_byte(8'hC0);
    send_byte(8'($urandom));
    k = last_cyc;
    idle(TO + 5);
    vectors++;
    if (got_fe.size() != 1 || got_wa.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL timeout_silence_count: got errors %0d writes %0d expected 1 0", got_fe.size(), got_wa.size());
    end else if (got_fe[0] !== k + TO + 1) begin
      miscompares++;
      $display("[TB] FAIL timeout_silence_cycle: got %0d expected %0d", got_fe[0], k + TO + 1);
    end
    // A byte landing on the timeout cycle is discarded, not taken as data or CMD.
    clear_all();
    send_byte(8'h80);
    send_byte(8'($urandom));
    send_byte(8'h01);
    k = last_cyc;
    idle(TO - 1);
    send_byte(8'h55);
    idle(3);
    send_write_frame({1'b1, 1'($urandom), 6'($urandom)}, 8'($urandom), 8'h03, 0);
    idle(4);
    vectors++;
    if (got_fe.size() != 1 || (got_fe.size() == 1 && got_fe[0] !== k + TO + 1)) begin
      miscompares++;
      $display("[TB] FAIL timeout_edge_error: got %0d pulses first at %0d expected 1 at %0d",
               got_fe.size(), (got_fe.size() > 0) ? got_fe[0] : -1, k + TO + 1);
    end
    vectors++;
    if (got_wa.size() != exp_wa.size()) begin
      miscompares++;
      $display("[TB] FAIL timeout_edge_count: got %0d writes expected %0d", got_wa.size(), exp_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
      vectors++;
      if (got_wa[i] !== exp_wa[i] || got_wd[i] !== exp_wd[i] || got_wc[i] !== exp_wc[i]) begin
        miscompares++;
        $display("[TB] FAIL timeout_recover_write[%0d]: got %0h=%0h@%0d expected %0h=%0h@%0d",
                 i, got_wa[i], got_wd[i], got_wc[i], exp_wa[i], exp_wd[i], exp_wc[i]);
      end
    end
  endtask

  task automatic test_len0();
    clear_all();
    send_write_frame({2'b10, 6'($urandom)}, 8'($urandom), 8'h00, 0);
    idle(4);
    vectors++;
    if (got_wa.size() != 256 || exp_wa.size() != 256) begin
      miscompares++;
      $display("[TB] FAIL len0_count: got %0d expected 256", got_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
      vectors++;
      if (got_wa[i] !== exp_wa[0] || got_wd[i] !== exp_wd[i] || got_wc[i] !== exp_wc[i]) begin
        miscompares++;
        $display("[TB] FAIL len0_write[%0d]: got %0h=%0h@%0d expected %0h=%0h@%0d",
                 i, got_wa[i], got_wd[i], got_wc[i], exp_wa[0], exp_wd[i], exp_wc[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int k;
    int n;
    ready_mode = 0;
    idle(2);
    clear_all();
    send_read_frame(8'h40, 8'($urandom), 8'h03, k);
    n = 0;
    while (m_axis_tvalid !== 1'b1 && n < 20) begin
      idle(1);
      n++;
    end
    vectors++;
    if (m_axis_tvalid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_precondition: got tvalid %b expected 1", m_axis_tvalid);
    end
    #2;
    res = 1'b1;
    #1;
    vectors++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || rfg_read !== 1'b0 || m_axis_tdata !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got tvalid %b tready %b read %b tdata %0h expected 0 1 0 0",
               m_axis_tvalid, s_axis_tready, rfg_read, m_axis_tdata);
    end
    @(posedge clk);
    #1;
    res = 1'b0;
    ready_mode = 1;
    idle(2);
    clear_all();
    send_write_frame({1'b1, 1'($urandom), 6'($urandom)}, 8'($urandom), 8'h02, 1);
    idle(4);
    vectors++;
    if (got_wa.size() != 2 || got_md.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_recover_count: got writes %0d bytes %0d expected 2 0", got_wa.size(), got_md.size());
    end
    for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
      vectors++;
      if (got_wa[i] !== exp_wa[i] || got_wd[i] !== exp_wd[i] || got_wc[i] !== exp_wc[i]) begin
        miscompares++;
        $display("[TB] FAIL midreset_recover_write[%0d]: got %0h=%0h@%0d expected %0h=%0h@%0d",
                 i, got_wa[i], got_wd[i], got_wc[i], exp_wa[i], exp_wd[i], exp_wc[i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'hFF] = 8'h12;
    rom[8'h00] = 8'h34;
    test_reset();
    test_write_basic();
    test_write_random();
    test_read_basic();
    test_read_random();
    test_read_stall();
    test_timeout();
    test_len0();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
